// File: rtl/mux_pkg.sv
// Shared state type and default sizing for the binary-tree valve multiplexer sequencer.
// MUX_HOLD_EN adds the HOLD state (path kept open between requests).
package mux_pkg;
    localparam int LEVELS_DEF        = 3;
    localparam int SETTLE_CYCLES_DEF = 16;
    localparam int DWELL_W_DEF       = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLOSE,
        OPEN,
`ifdef MUX_HOLD_EN
        DWELL,
        HOLD
`else
        DWELL
`endif
    } mux_state_t;
endpackage

// File: rtl/mux_timer.sv
// Loadable saturating down-counter; tc is high while the count sits at zero.
module mux_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/multiplexer_seq_ctrl.sv
// Break-before-make sequencer for a binary-tree pneumatic multiplexer.
// Optional MUX_HOLD_EN keeps the routed path open after the dwell.
module multiplexer_seq_ctrl
    import mux_pkg::*;
#(
    parameter int LEVELS        = LEVELS_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int DWELL_W       = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LEVELS-1:0]  req_chan,
    input  logic [DWELL_W-1:0] req_dwell,
    input  logic               abort,
    output logic [LEVELS-1:0]  c_0,
    output logic [LEVELS-1:0]  c_1,
    output logic               busy,
    output logic               done,
    output logic [LEVELS-1:0]  cur_chan,
    output logic               path_open
);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    mux_state_t         state, state_nxt;
    logic [LEVELS-1:0]  chan_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               init_q;
    logic               accept;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_tc;

    // Level L is driven by bit L-1 of the lines but selected by bit LEVELS-L of the channel.
    function automatic logic [LEVELS-1:0] path_c0(input logic [LEVELS-1:0] k);
        logic [LEVELS-1:0] r;
        for (int i = 0; i < LEVELS; i++) r[i] = k[LEVELS-1-i];
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : (CNT_W'(d) - CNT_W'(1));
    endfunction

    mux_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (busy),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            chan_q <= '0;
            init_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            init_q <= 1'b1;
            if (accept) chan_q <= req_chan;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) dwell_q <= req_dwell;
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = SETTLE_LOAD;
        c_0       = '1;
        c_1       = '1;
        busy      = 1'b0;
        req_ready = 1'b0;
        done      = 1'b0;
        path_open = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // Ready drops under abort so a handshake never completes without being taken.
                req_ready = init_q && !abort;
                if (req_valid && req_ready) begin
                    accept    = 1'b1;
                    state_nxt = CLOSE;
                    tmr_load  = 1'b1;
                end
            end
            CLOSE: begin
                busy = 1'b1;
                if (tmr_tc) begin
                    state_nxt = OPEN;
                    tmr_load  = 1'b1;
                end
            end
            OPEN: begin
                busy = 1'b1;
                c_0  = path_c0(chan_q);
                c_1  = ~path_c0(chan_q);
                if (tmr_tc) begin
                    state_nxt = DWELL;
                    tmr_load  = 1'b1;
                    tmr_val   = dwell_load(dwell_q);
                end
            end
            DWELL: begin
                busy      = 1'b1;
                path_open = 1'b1;
                c_0       = path_c0(chan_q);
                c_1       = ~path_c0(chan_q);
                if (tmr_tc) begin
                    done = !abort;
`ifdef MUX_HOLD_EN
                    state_nxt = HOLD;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef MUX_HOLD_EN
            HOLD: begin
                path_open = 1'b1;
                c_0       = path_c0(chan_q);
                c_1       = ~path_c0(chan_q);
                req_ready = !abort;
                if (req_valid && req_ready) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    // Same channel is already routed: go straight back to dwelling.
                    if (req_chan == chan_q) begin
                        state_nxt = DWELL;
                        tmr_val   = dwell_load(req_dwell);
                    end else begin
                        state_nxt = CLOSE;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            tmr_load  = 1'b0;
        end
    end

    assign cur_chan = chan_q;
endmodule

// File: tb/tb_multiplexer_seq_ctrl.sv
// Self-checking bench for multiplexer_seq_ctrl: timeline reference model plus directed literals.
module tb_multiplexer_seq_ctrl;
    localparam int LV = 3;
    localparam int S  = 16;
    localparam int DW = 16;
`ifdef MUX_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [LV-1:0] req_chan = '0;
    logic [DW-1:0] req_dwell = '0;
    logic          abort = 1'b0;
    logic [LV-1:0] c_0, c_1, cur_chan;
    logic          busy, done, path_open;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    multiplexer_seq_ctrl #(.LEVELS(LV), .SETTLE_CYCLES(S), .DWELL_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_chan  (req_chan),
        .req_dwell (req_dwell),
        .abort     (abort),
        .c_0       (c_0),
        .c_1       (c_1),
        .busy      (busy),
        .done      (done),
        .cur_chan  (cur_chan),
        .path_open (path_open)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Channel k vents line b = bit (LV-L) of k at level L and pressurises its sibling.
    function automatic logic [2*LV-1:0] route(input int k);
        logic [LV-1:0] a0, a1;
        int b;
        for (int L = 1; L <= LV; L++) begin
            b = (k >> (LV - L)) & 1;
            if (b == 1) begin a1[L-1] = 1'b0; a0[L-1] = 1'b1; end
            else        begin a0[L-1] = 1'b0; a1[L-1] = 1'b1; end
        end
        return {a1, a0};
    endfunction

    // Reference model: each accepted request becomes a timeline anchored at its accept cycle.
    bit  act = 0, holding = 0, armed = 0, skip = 0;
    int  t0 = 0, m_chan = 0, m_dwell = 0;
    bit  seen [8];

    always @(negedge clk) begin
        logic [LV-1:0] e_c0, e_c1;
        logic e_busy, e_ready, e_done, e_po;
        int rel, pre, dlen;
        if (!rst_n) begin
            chk("rst_c_0", c_0, 3'b111);
            chk("rst_c_1", c_1, 3'b111);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_path_open", path_open, 0);
            chk("rst_cur_chan", cur_chan, 0);
            act = 0; holding = 0; armed = 0;
        end else begin
            e_c0 = '1; e_c1 = '1; e_busy = 0; e_ready = 0; e_done = 0; e_po = 0;
            rel = cyc - t0;
            pre = skip ? 0 : 2 * S;
            dlen = (m_dwell == 0) ? 1 : m_dwell;
            if (act) begin
                e_busy = 1;
                if (rel > (skip ? 0 : S)) {e_c1, e_c0} = route(m_chan);
                if (rel > pre) e_po = 1;
                if (rel == pre + dlen && !abort) e_done = 1;
            end else if (holding) begin
                {e_c1, e_c0} = route(m_chan);
                e_po = 1;
                e_ready = !abort;
            end else begin
                e_ready = armed && !abort;
            end
            chk("c_0", c_0, e_c0);
            chk("c_1", c_1, e_c1);
            chk("busy", busy, e_busy);
            chk("req_ready", req_ready, e_ready);
            chk("done", done, e_done);
            chk("path_open", path_open, e_po);
            if (e_po) chk("cur_chan", cur_chan, m_chan);
            if (busy || path_open) chk("sibling_vent", c_0 | c_1, 3'b111);
            chk("ready_while_busy", req_ready && busy, 0);
            if (path_open) seen[cur_chan] = 1;

            if (abort) begin
                act = 0; holding = 0;
            end else if (act && rel == pre + dlen) begin
                act = 0; holding = HOLD_EN;
            end else if (e_ready && req_valid) begin
                skip = holding && (int'(req_chan) == m_chan);
                act = 1; holding = 0; t0 = cyc;
                m_chan = req_chan; m_dwell = req_dwell;
            end
            armed = 1;
        end
    end

    logic [LV-1:0] snap0 [0:127];
    logic [LV-1:0] snap1 [0:127];

    task automatic send(input int ch, input int dw, output bit ok);
        @(posedge clk); #1;
        req_chan = LV'(ch); req_dwell = DW'(dw); req_valid = 1'b1; ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    // Starts right after the accept edge; n counts cycles since the accept cycle.
    task automatic watch(input int limit, output int n_done);
        n_done = -1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            snap0[n] = c_0; snap1[n] = c_1;
            if (done) begin n_done = n; break; end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int nd, dcount;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t037_rst_c_0", c_0, 3'b111);
        chk("t037_rst_c_1", c_1, 3'b111);
        chk("t037_rst_done", done, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t037_ready_not_yet", req_ready, 0);
        @(negedge clk);
        chk("t037_ready_after_release", req_ready, 1);

        send(5, 4, ok);
        watch(100, nd);
        chk("t038_done_cycle", nd, 36);
        chk("t038_close_first_c_0", snap0[1], 3'b111);
        chk("t038_close_last_c_1", snap1[16], 3'b111);
        chk("t038_open_c_1", snap1[17], 3'b010);
        chk("t038_open_c_0", snap0[17], 3'b101);
        @(negedge clk);
        chk("t038_after_done_c_0", c_0, HOLD_EN ? 3'b101 : 3'b111);
        chk("t038_after_done_c_1", c_1, HOLD_EN ? 3'b010 : 3'b111);

        send(3, 3, ok);
        repeat (34) @(negedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk);
        chk("t039_no_done_on_abort", done, 0);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("t039_idle_c_0", c_0, 3'b111);
        chk("t039_idle_c_1", c_1, 3'b111);
        chk("t039_idle_busy", busy, 0);
        chk("t039_idle_ready", req_ready, 1);
        dcount = 0;
        repeat (5) begin @(negedge clk); if (done) dcount++; end
        chk("t039_no_late_done", dcount, 0);

        send(1, 0, ok);
        watch(100, nd);
        chk("t040_done_cycle", nd, 33);
        chk("t040_dwell_c_0", snap0[33], 3'b100);
        chk("t040_open_c_1", snap1[32], 3'b011);

`ifdef MUX_HOLD_EN
        send(2, 5, ok);
        watch(100, nd);
        chk("t041_first_done", nd, 37);
        @(negedge clk);
        chk("t041_hold_path_open", path_open, 1);
        chk("t041_hold_busy", busy, 0);
        chk("t041_hold_ready", req_ready, 1);
        chk("t041_hold_c_0", c_0, 3'b010);
        send(2, 5, ok);
        watch(100, nd);
        chk("t041_same_chan_done", nd, 5);
        chk("t041_same_chan_no_close", snap0[1], 3'b010);
        send(6, 2, ok);
        watch(100, nd);
        chk("t041_new_chan_done", nd, 34);
        chk("t041_new_chan_close_c_0", snap0[1], 3'b111);
        chk("t041_new_chan_close_c_1", snap1[16], 3'b111);
        chk("t041_new_chan_open_c_0", snap0[17], 3'b011);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("t041_abort_leaves_hold", path_open, 0);
`endif

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 3) == 0);
            req_chan  = LV'($urandom_range(0, 7));
            req_dwell = DW'($urandom_range(0, 6));
            abort     = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; abort = 1'b0;
        repeat (5) @(posedge clk);

        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_c_0", c_0, 3'b111);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_path_open", path_open, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 8; k++) chk($sformatf("chan_reached_%0d", k), seen[k], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
